bar_spectrum_engine: RTL and testbench
======================================

// Module: bar_spectrum_engine
// PURPOSE
//  Parametrised spectrum-bar engine between the FFT audio buffer and the VGA bar painter.
//  On each frame tick it snapshots the packed magnitude vector and updates one bar per clock.
//  Per bar it applies a mode-selected display height: raw, smoothed (fast attack / slow decay)
//  or smoothed with a peak-hold marker.
//  Publishes bar geometry, heights, peak markers and the tallest bar atomically, once per frame.
// PARAMETERS
//  BAR_COUNT    16   number of bars/channels, 1..64
//  SAMPLE_W     32   bits per packed audio word
//  MAG_LSB      22   lowest magnitude bit taken from each word
//  MAG_BITS     6    magnitude bits taken (MAG_LSB+MAG_BITS <= SAMPLE_W), 1..10
//  SCREEN_W     640  horizontal span in pixels
//  Y_BASE       240  bar_y value for every bar
//  DECAY_SHIFT  2    smoothing decay = (cur-raw)>>DECAY_SHIFT, minimum 1
//  PEAK_HOLD    30   frames a peak marker holds before falling
// PORTS
//  Clk            in   1                     system clock
//  Reset_n        in   1                     asynchronous, active-low reset
//  frame_tick     in   1                     1-cycle pulse per video frame (vsync-derived)
//  mode           in   2                     0 raw, 1 smoothed, 2 smoothed+peak, 3 = 2
//  audio_output   in   BAR_COUNT*SAMPLE_W    packed magnitude words, word i at [i*SAMPLE_W +: SAMPLE_W]
//  num_bars       out  10                    constant BAR_COUNT
//  bar_width      out  10                    constant SCREEN_W/BAR_COUNT (truncating)
//  bar_x          out  10 x BAR_COUNT        constant i*bar_width
//  bar_y          out  10 x BAR_COUNT        constant Y_BASE
//  bar_height     out  10 x BAR_COUNT        published display height
//  peak_height    out  10 x BAR_COUNT        published peak marker height (0 in modes 0/1)
//  max_idx        out  6                     index of tallest published bar
//  max_x          out  10                    bar_x[max_idx]
//  busy           out  1                     high while not in IDLE
//  frame_done     out  1                     1-cycle pulse when outputs are republished
//  frame_overrun  out  1                     1-cycle pulse: frame_tick arrived while busy
// BEHAVIOUR
//  Reset: state IDLE; bar_height, peak_height, hold counters, working regs, max_idx, max_x,
//   busy, frame_done, frame_overrun all 0. Reset during a frame aborts it; no partial publish.
//  FSM IDLE -> SNAP -> RUN -> PUBLISH -> IDLE.
//   IDLE: frame_tick -> SNAP.
//   SNAP (1 cycle): register audio_output and mode into shadow regs; idx=0; clear running max.
//   RUN (BAR_COUNT cycles): process bar idx; idx++; after last bar -> PUBLISH.
//   PUBLISH (1 cycle): copy working regs to outputs; frame_done=1; -> IDLE.
//  frame_tick -> frame_done latency = BAR_COUNT+2 cycles.
//  frame_tick outside IDLE: ignored; frame_overrun pulses the next cycle.
//  Input mode and audio_output changes mid-frame have no effect; only the SNAP copy is used.
//  Per bar: raw = {zero-pad, word[MAG_LSB +: MAG_BITS]}, 10-bit.
//   mode 0: disp = raw.
//   mode 1/2: if raw >= cur then disp = raw;
//    else disp = cur - max(1, (cur-raw)>>DECAY_SHIFT); never below raw.
//   mode 2 peak:
//    - if disp >= pk: pk = disp, hold = PEAK_HOLD;
//    - else if hold != 0: hold--;
//    - else pk = max(disp, pk-1).
//   modes 0/1: pk = 0, hold = 0. Smoothing state persists across mode changes.
//  Max: a running compare of disp updates only on strictly greater, so ties keep the lowest
//   index; an all-zero frame gives max_idx = 0.
//  bar_x, bar_y, bar_width and num_bars are combinational constants and unaffected by reset.
//  All arithmetic is unsigned 10-bit with no wrap: subtraction is guarded by its comparison.
// STRUCTURE
//  Package bar_pkg: HEIGHT_W=10; typedef enum {BM_RAW, BM_SMOOTH, BM_PEAK} bar_mode_t;
//   typedef enum {S_IDLE, S_SNAP, S_RUN, S_PUBLISH} bar_state_t; typedef logic [9:0] height_t.
//  Sub-module bar_channel_update: combinational, single shared instance.
//   Inputs raw, cur, pk, hold and mode; outputs next disp, pk and hold.
//  Top: FSM, shadow regs, working arrays indexed by idx, output registers, max tracker.
// TESTING
//  1. Reset_n low mid-RUN -> all outputs 0 next cycle; no frame_done pulse; busy=0.
//  2. BAR_COUNT=16, mode 0, word i magnitude = i -> frame_done 18 cycles after tick;
//     bar_height[i]=i; max_idx=15; max_x=600.
//  3. mode 1, bar 0: raw 40 then 0 repeatedly -> 40, 30, 23, 18, ... down to 0 (min step 1).
//  4. mode 2, one frame raw 50 then 0 -> peak_height stays 50 for 30 frames, then falls 1 per
//     frame, never below bar_height.
//  5. Second frame_tick 5 cycles after the first -> frame_overrun pulses once; exactly one frame_done.
//  6. All bars equal 20 -> max_idx=0; audio_output changed during RUN -> published values from SNAP.

Source files
------------

// File: rtl/bar_spectrum_engine_pkg.sv
// Shared types for the spectrum-bar engine: height/hold widths, display modes, FSM states.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package bar_pkg;

  localparam int HEIGHT_W = 10;
  localparam int HOLD_W   = 8;

  typedef logic [HEIGHT_W-1:0] height_t;
  typedef logic [HOLD_W-1:0]   hold_t;

  typedef enum logic [1:0] {
    BM_RAW    = 2'd0,
    BM_SMOOTH = 2'd1,
    BM_PEAK   = 2'd2
  } bar_mode_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SNAP    = 2'd1,
    S_RUN     = 2'd2,
    S_PUBLISH = 2'd3
  } bar_state_t;

  // Encoding 3 is an alias of smoothed+peak.
  function automatic bar_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return BM_RAW;
      2'd1:    return BM_SMOOTH;
      default: return BM_PEAK;
    endcase
  endfunction

endpackage

// File: rtl/bar_spectrum_engine_if.sv
// Bus between the FFT buffer / frame timing side and the spectrum engine, plus painter outputs.
// Latency: n/a (wires only).
// Backpressure: none; frame_tick is a pulse, results are published with a frame_done pulse.
// Ports (slave = engine): in frame_tick, mode, audio_output; out geometry, heights, peaks,
//   max_idx/max_x, busy, frame_done, frame_overrun.
interface bar_spectrum_engine_if #(
  parameter int BAR_COUNT = 16,
  parameter int SAMPLE_W  = 32
) ();
  import bar_pkg::*;

  logic                          frame_tick;
  logic [1:0]                    mode;
  logic [BAR_COUNT*SAMPLE_W-1:0] audio_output;

  height_t                       num_bars;
  height_t                       bar_width;
  height_t                       bar_x       [BAR_COUNT];
  height_t                       bar_y       [BAR_COUNT];
  height_t                       bar_height  [BAR_COUNT];
  height_t                       peak_height [BAR_COUNT];
  logic [5:0]                    max_idx;
  height_t                       max_x;
  logic                          busy;
  logic                          frame_done;
  logic                          frame_overrun;

  modport master (
    output frame_tick, mode, audio_output,
    input  num_bars, bar_width, bar_x, bar_y, bar_height, peak_height,
           max_idx, max_x, busy, frame_done, frame_overrun
  );

  modport slave (
    input  frame_tick, mode, audio_output,
    output num_bars, bar_width, bar_x, bar_y, bar_height, peak_height,
           max_idx, max_x, busy, frame_done, frame_overrun
  );

endinterface

// File: rtl/bar_spectrum_engine_channel_update.sv
// Per-bar next-state logic: display height (raw / fast-attack slow-decay) and peak-hold marker.
// Latency: combinational, shared by all bars (one bar evaluated per clock by the top).
// Backpressure: none.
// Ports: in raw, cur, pk, hold, mode; out disp_next, pk_next, hold_next.
module bar_channel_update
  import bar_pkg::*;
#(
  parameter int DECAY_SHIFT = 2,
  parameter int PEAK_HOLD   = 30
) (
  input  height_t   raw,
  input  height_t   cur,
  input  height_t   pk,
  input  hold_t     hold,
  input  bar_mode_t mode,
  output height_t   disp_next,
  output height_t   pk_next,
  output hold_t     hold_next
);

  height_t diff;
  height_t step;
  height_t pk_dec;

  always_comb begin
    // diff/step are only consumed when cur > raw, so the subtraction never wraps in use.
    diff = cur - raw;
    step = diff >> DECAY_SHIFT;
    if (step == '0) begin
      step = height_t'(1);
    end
    // step <= cur - raw, so the decayed value can never drop below raw.
    disp_next = raw;
    if ((mode != BM_RAW) && (raw < cur)) begin
      disp_next = cur - step;
    end

    pk_dec    = pk - height_t'(1);
    pk_next   = '0;
    hold_next = '0;
    if (mode == BM_PEAK) begin
      if (disp_next >= pk) begin
        pk_next   = disp_next;
        hold_next = hold_t'(PEAK_HOLD);
      end else if (hold != '0) begin
        pk_next   = pk;
        hold_next = hold - hold_t'(1);
      end else begin
        // pk > disp_next here, so pk >= 1 and pk_dec is valid.
        pk_next   = (pk_dec > disp_next) ? pk_dec : disp_next;
        hold_next = '0;
      end
    end
  end

endmodule

// File: rtl/bar_spectrum_engine.sv
// Spectrum-bar engine: per frame, snapshot magnitudes, update one bar per clock, publish atomically.
// Latency: frame_tick to frame_done = BAR_COUNT+2 cycles.
// Backpressure: none; a frame_tick while busy is dropped and flagged by a frame_overrun pulse.
// Ports: Clk, Reset_n (async active-low), bus (slave modport of bar_spectrum_engine_if).
module bar_spectrum_engine
  import bar_pkg::*;
#(
  parameter int BAR_COUNT   = 16,
  parameter int SAMPLE_W    = 32,
  parameter int MAG_LSB     = 22,
  parameter int MAG_BITS    = 6,
  parameter int SCREEN_W    = 640,
  parameter int Y_BASE      = 240,
  parameter int DECAY_SHIFT = 2,
  parameter int PEAK_HOLD   = 30
) (
  input logic                    Clk,
  input logic                    Reset_n,
  bar_spectrum_engine_if.slave   bus
);

  localparam int IDX_W = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
  localparam int BAR_W = SCREEN_W / BAR_COUNT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BAR_COUNT - 1);

  bar_state_t          state;
  logic [IDX_W-1:0]    idx;
  bar_mode_t           shadow_mode;
  logic [MAG_BITS-1:0] shadow_mag   [BAR_COUNT];

  height_t             cur_w        [BAR_COUNT];
  height_t             pk_w         [BAR_COUNT];
  hold_t               hold_w       [BAR_COUNT];
  height_t             run_max;
  logic [IDX_W-1:0]    run_idx;

  height_t             bar_height_q [BAR_COUNT];
  height_t             peak_q       [BAR_COUNT];
  logic [5:0]          max_idx_q;
  height_t             max_x_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;

  height_t             raw;
  height_t             disp_next;
  height_t             pk_next;
  hold_t               hold_next;

  assign raw = height_t'(shadow_mag[idx]);

  bar_channel_update #(
    .DECAY_SHIFT (DECAY_SHIFT),
    .PEAK_HOLD   (PEAK_HOLD)
  ) u_chan (
    .raw       (raw),
    .cur       (cur_w[idx]),
    .pk        (pk_w[idx]),
    .hold      (hold_w[idx]),
    .mode      (shadow_mode),
    .disp_next (disp_next),
    .pk_next   (pk_next),
    .hold_next (hold_next)
  );

  // Geometry is fixed by parameters and deliberately independent of reset.
  assign bus.num_bars  = height_t'(BAR_COUNT);
  assign bus.bar_width = height_t'(BAR_W);
  for (genvar g = 0; g < BAR_COUNT; g++) begin : g_geom
    assign bus.bar_x[g] = height_t'(g * BAR_W);
    assign bus.bar_y[g] = height_t'(Y_BASE);
  end

  assign bus.bar_height    = bar_height_q;
  assign bus.peak_height   = peak_q;
  assign bus.max_idx       = max_idx_q;
  assign bus.max_x         = max_x_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_overrun = overrun_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      shadow_mode <= BM_RAW;
      run_max     <= '0;
      run_idx     <= '0;
      max_idx_q   <= '0;
      max_x_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < BAR_COUNT; i++) begin
        shadow_mag[i]   <= '0;
        cur_w[i]        <= '0;
        pk_w[i]         <= '0;
        hold_w[i]       <= '0;
        bar_height_q[i] <= '0;
        peak_q[i]       <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= bus.frame_tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.frame_tick) begin
            state  <= S_SNAP;
            busy_q <= 1'b1;
          end
        end
        S_SNAP: begin
          // Only the magnitude field of each word is kept; later input changes are ignored.
          for (int i = 0; i < BAR_COUNT; i++) begin
            shadow_mag[i] <= bus.audio_output[i*SAMPLE_W + MAG_LSB +: MAG_BITS];
          end
          shadow_mode <= decode_mode(bus.mode);
          idx         <= '0;
          run_max     <= '0;
          run_idx     <= '0;
          state       <= S_RUN;
        end
        S_RUN: begin
          cur_w[idx]  <= disp_next;
          pk_w[idx]   <= pk_next;
          hold_w[idx] <= hold_next;
          // Strictly greater keeps the lowest index on ties and index 0 for an all-zero frame.
          if (disp_next > run_max) begin
            run_max <= disp_next;
            run_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            state <= S_PUBLISH;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_PUBLISH: begin
          bar_height_q <= cur_w;
          peak_q       <= pk_w;
          max_idx_q    <= 6'(run_idx);
          max_x_q      <= height_t'(int'(run_idx) * BAR_W);
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bar_spectrum_engine.sv
`timescale 1ns/1ps
module tb_bar_spectrum_engine;
  import bar_pkg::*;

  localparam int BC  = 16;
  localparam int SW  = 32;
  localparam int LSB = 22;
  localparam int MB  = 6;
  localparam int SCR = 640;
  localparam int YB  = 240;
  localparam int DS  = 2;
  localparam int PH  = 30;
  localparam int LAT = BC + 2;
  localparam int BW  = SCR / BC;
  localparam int unsigned FIELD = ((32'd1 << MB) - 1) << LSB;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  bar_spectrum_engine_if #(.BAR_COUNT(BC), .SAMPLE_W(SW)) bus ();

  bar_spectrum_engine #(
    .BAR_COUNT(BC), .SAMPLE_W(SW), .MAG_LSB(LSB), .MAG_BITS(MB), .SCREEN_W(SCR),
    .Y_BASE(YB), .DECAY_SHIFT(DS), .PEAK_HOLD(PH)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cur [BC];
  int m_pk  [BC];
  int m_hold[BC];
  int m_midx;
  int pub_h [BC];
  int pub_pk[BC];
  int pub_midx;
  int age = -1;        // negedges since the accepted tick was first seen; -1 = idle
  bit ov_pend = 0;

  function automatic void model_reset();
    for (int i = 0; i < BC; i++) begin
      m_cur[i] = 0; m_pk[i] = 0; m_hold[i] = 0; pub_h[i] = 0; pub_pk[i] = 0;
    end
    m_midx = 0; pub_midx = 0; age = -1; ov_pend = 0;
  endfunction

  function automatic void model_frame(input int mode_in, input logic [BC*SW-1:0] aud);
    int m, raw, d, mx;
    m = (mode_in == 3) ? 2 : mode_in;
    mx = 0; m_midx = 0;
    for (int i = 0; i < BC; i++) begin
      raw = int'(aud >> (i*SW + LSB)) & ((1 << MB) - 1);
      if (m == 0 || raw >= m_cur[i]) d = raw;
      else d = m_cur[i] - (((m_cur[i] - raw) >> DS) > 1 ? ((m_cur[i] - raw) >> DS) : 1);
      if (m == 2) begin
        if (d >= m_pk[i]) begin m_pk[i] = d; m_hold[i] = PH; end
        else if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
        else m_pk[i] = (m_pk[i] - 1 > d) ? m_pk[i] - 1 : d;
      end else begin
        m_pk[i] = 0; m_hold[i] = 0;
      end
      m_cur[i] = d;
      if (d > mx) begin mx = d; m_midx = i; end
    end
  endfunction

  // Single compare process: every negedge, all published outputs against the model.
  always @(negedge Clk) begin
    int bi, pi;
    bit bsy;
    if (!Reset_n) begin
      model_reset();
    end else begin
      if (age >= 0) age++;
      if (age == 1) model_frame(int'(bus.mode), bus.audio_output);
      if (age == LAT + 1) begin
        pub_h = m_cur; pub_pk = m_pk; pub_midx = m_midx;
      end
    end
    bsy = (age >= 1) && (age <= LAT);
    chk("frame_done", bus.frame_done, 32'(age == LAT + 1));
    chk("busy", bus.busy, 32'(bsy));
    chk("frame_overrun", bus.frame_overrun, 32'(ov_pend));
    bi = 0; pi = 0;
    for (int i = BC - 1; i >= 0; i--) begin
      if (bus.bar_height[i] !== 10'(pub_h[i])) bi = i;
      if (bus.peak_height[i] !== 10'(pub_pk[i])) pi = i;
    end
    chk($sformatf("bar_height[%0d]", bi), bus.bar_height[bi], pub_h[bi]);
    chk($sformatf("peak_height[%0d]", pi), bus.peak_height[pi], pub_pk[pi]);
    chk("max_idx", bus.max_idx, pub_midx);
    chk("max_x", bus.max_x, pub_midx * BW);
    if (Reset_n) begin
      ov_pend = bus.frame_tick && bsy;
      if (age == LAT + 1) age = -1;
      if (bus.frame_tick && !bsy) age = 0;
    end
  end

  // ---------------- stimulus ----------------
  int stim_mag[BC];

  task automatic drive_words();
    int unsigned w;
    for (int i = 0; i < BC; i++) begin
      w = $urandom;
      w = (w & ~FIELD) | (int'(stim_mag[i]) << LSB);
      bus.audio_output[i*SW +: SW] = w;
    end
  endtask

  task automatic rand_mags();
    for (int i = 0; i < BC; i++) stim_mag[i] = $urandom_range(0, (1 << MB) - 1);
  endtask

  // One frame: tick, optional overlapping tick / input scramble, bounded wait for frame_done.
  task automatic run_frame(input int m, input int extra_at, input int scramble_at);
    int lat, nov;
    bus.mode = 2'(m);
    drive_words();
    @(posedge Clk); #1 bus.frame_tick = 1'b1;
    @(posedge Clk); #1 bus.frame_tick = 1'b0;
    lat = -1; nov = 0;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(posedge Clk); #1;
      if (bus.frame_overrun) nov++;
      if (bus.frame_done) lat = (lat < 0) ? c : 1000;
      if (c == extra_at) bus.frame_tick = 1'b1;
      if (c == extra_at + 1) bus.frame_tick = 1'b0;
      if (c == scramble_at) begin
        rand_mags(); drive_words(); bus.mode = 2'($urandom_range(0, 3));
      end
    end
    chk("frame latency", lat, LAT);
    chk("overrun pulses", nov, (extra_at > 0) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp3[14] = '{30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    int nd;
    bus.frame_tick = 1'b0;
    bus.mode = 2'd0;
    bus.audio_output = '0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("num_bars", bus.num_bars, BC);
    chk("bar_width", bus.bar_width, 40);
    chk("bar_x[15]", bus.bar_x[15], 600);
    chk("bar_y[7]", bus.bar_y[7], YB);
    chk("reset max_x", bus.max_x, 0);
    Reset_n = 1'b1;

    // Ramp: magnitude i on bar i in raw mode.
    for (int i = 0; i < BC; i++) stim_mag[i] = i;
    run_frame(0, 0, 0);
    for (int i = 0; i < BC; i++) chk($sformatf("ramp bar_height[%0d]", i), bus.bar_height[i], i);
    chk("ramp max_idx", bus.max_idx, 15);
    chk("ramp max_x", bus.max_x, 600);

    // Smoothing decay on bar 0.
    rand_mags(); stim_mag[0] = 40;
    run_frame(1, 0, 0);
    chk("smooth attack", bus.bar_height[0], 40);
    for (int k = 0; k < 14; k++) begin
      rand_mags(); stim_mag[0] = 0;
      run_frame(1, 0, 0);
      chk($sformatf("smooth decay step %0d", k), bus.bar_height[0], exp3[k]);
    end

    // Peak hold on bar 0.
    rand_mags(); stim_mag[0] = 50;
    run_frame(2, 0, 0);
    chk("peak capture", bus.peak_height[0], 50);
    for (int k = 0; k < PH; k++) begin
      rand_mags(); stim_mag[0] = 0;
      run_frame((k % 2) ? 3 : 2, 0, 0);
    end
    chk("peak held", bus.peak_height[0], 50);
    rand_mags(); stim_mag[0] = 0;
    run_frame(2, 0, 0);
    chk("peak falls", bus.peak_height[0], 49);
    chk("peak bar decayed", bus.bar_height[0], 0);

    // Overlapping tick 5 cycles after the first.
    rand_mags();
    run_frame(1, 4, 0);

    // Equal bars, inputs scrambled during RUN.
    for (int i = 0; i < BC; i++) stim_mag[i] = 20;
    run_frame(0, 0, 4);
    chk("tie max_idx", bus.max_idx, 0);
    chk("snap bar_height[15]", bus.bar_height[15], 20);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      rand_mags();
      run_frame($urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(2, 17) : 0);
      repeat ($urandom_range(0, 3)) @(posedge Clk);
    end

    // Reset in the middle of RUN aborts the frame.
    rand_mags(); bus.mode = 2'd2; drive_words();
    @(posedge Clk); #1 bus.frame_tick = 1'b1;
    @(posedge Clk); #1 bus.frame_tick = 1'b0;
    repeat (8) @(posedge Clk);
    #1 Reset_n = 1'b0;
    @(posedge Clk); #1;
    chk("abort busy", bus.busy, 0);
    chk("abort bar_height[0]", bus.bar_height[0], 0);
    chk("abort max_idx", bus.max_idx, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (bus.frame_done) nd++;
    end
    chk("no done after abort", nd, 0);

    rand_mags();
    run_frame(2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
